// File: rtl/instr_exec_fsm.sv
// Decode/execute controller: sequences register-file, ALU and memory strobes for one
// latched instruction, then pulses done so fetch can restart.
module instr_exec_fsm #(
    parameter int IR_W        = 16,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ir_valid,
    input  logic [IR_W-1:0] ir,
    input  logic            MFC,
    output logic [2:0]      rf_ra,
    output logic [2:0]      rf_rb,
    output logic            rf_wr_en,
    output logic [2:0]      rf_wa,
    output logic [1:0]      alu_op,
    output logic            MARin,
    output logic            memEN,
    output logic            RW,
    output logic            MDRreadEN,
    output logic            MDRout,
    output logic            MDRin,
    output logic            PCload,
    output logic            done,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    localparam int CW = $clog2(MFC_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MFC_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        IDLE, DECODE, EXEC, WB, MADDR, MEM_WAIT, MEM_LAT, LD_WB, JUMP, DONE, HALT, ERR
    } state_t;

    state_t          state;
    logic [IR_W-1:3] ir_q;
    logic [CW-1:0]   cnt;

    logic [3:0] opc;
    logic [2:0] rd, ra, rb;
    logic [3:0] opm1;
    logic       is_load, is_store;
    logic       unused_ir_bits;

    // Low three IR bits only matter for the imm/addr field, which fetch drives directly.
    assign unused_ir_bits = ^ir[2:0];
    assign opc      = ir_q[15:12];
    assign rd       = ir_q[11:9];
    assign ra       = ir_q[8:6];
    assign rb       = ir_q[5:3];
    assign opm1     = opc - 4'd1;
    assign is_load  = (opc == OP_LOAD);
    assign is_store = (opc == OP_STORE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ir_q      <= '0;
            cnt       <= '0;
            rf_ra     <= '0;
            rf_rb     <= '0;
            rf_wr_en  <= 1'b0;
            rf_wa     <= '0;
            alu_op    <= '0;
            MARin     <= 1'b0;
            memEN     <= 1'b0;
            RW        <= 1'b0;
            MDRreadEN <= 1'b0;
            MDRout    <= 1'b0;
            MDRin     <= 1'b0;
            PCload    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Strobes are a registered decode of the state held this cycle.
            rf_ra     <= (state == EXEC) ? ra : 3'd0;
            rf_rb     <= (state == EXEC || (state == MADDR && is_store)) ? rb : 3'd0;
            alu_op    <= (state == EXEC) ? opm1[1:0] : 2'd0;
            rf_wr_en  <= (state == WB || state == LD_WB);
            rf_wa     <= (state == WB || state == LD_WB) ? rd : 3'd0;
            MARin     <= (state == MADDR);
            MDRin     <= (state == MADDR) && is_store;
            memEN     <= (state == MEM_WAIT) || (state == MEM_LAT && is_load);
            RW        <= (state == MEM_WAIT || state == MEM_LAT) && is_load;
            MDRreadEN <= (state == MEM_LAT) && is_load;
            MDRout    <= (state == LD_WB);
            PCload    <= (state == JUMP);
            done      <= (state == DONE);
            busy      <= !(state == IDLE || state == HALT || state == ERR);
            halted    <= (state == HALT);
            err       <= (state == ERR);

            case (state)
                IDLE: if (ir_valid) begin
                    ir_q  <= ir[IR_W-1:3];
                    state <= DECODE;
                end
                DECODE: begin
                    case (opc)
                        OP_NOP:                        state <= DONE;
                        OP_ADD, OP_SUB, OP_AND, OP_OR: state <= EXEC;
                        OP_LOAD, OP_STORE:             state <= MADDR;
                        OP_JMP:                        state <= JUMP;
                        OP_HALT:                       state <= HALT;
                        default:                       state <= ERR;
                    endcase
                end
                EXEC:  state <= WB;
                WB:    state <= DONE;
                MADDR: begin
                    cnt   <= '0;
                    state <= MEM_WAIT;
                end
                // MFC is checked first so a completion on the last allowed cycle still wins.
                MEM_WAIT: begin
                    if (MFC)                  state <= MEM_LAT;
                    else if (cnt == CNT_LAST) state <= ERR;
                    else                      cnt   <= cnt + CNT_ONE;
                end
                MEM_LAT: state <= is_load ? LD_WB : DONE;
                LD_WB:   state <= DONE;
                JUMP:    state <= DONE;
                DONE:    state <= IDLE;
                HALT:    state <= HALT;
                ERR:     state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_fsm.sv
// Randomized bench for instr_exec_fsm: every cycle's outputs are compared against a
// per-cycle timeline derived from the instruction latency rules.
module tb_instr_exec_fsm;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_valid;
    logic [15:0] ir;
    logic        MFC;
    logic [2:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_wr_en;
    logic [1:0]  alu_op;
    logic        MARin, memEN, RW, MDRreadEN, MDRout, MDRin, PCload, done, busy, halted, err;

    int nchk  = 0;
    int nfail = 0;

    instr_exec_fsm #(.IR_W(16), .MFC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir(ir), .MFC(MFC),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wr_en(rf_wr_en), .rf_wa(rf_wa), .alu_op(alu_op),
        .MARin(MARin), .memEN(memEN), .RW(RW), .MDRreadEN(MDRreadEN), .MDRout(MDRout),
        .MDRin(MDRin), .PCload(PCload), .done(done), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    logic [21:0] got;
    assign got = {rf_ra, rf_rb, rf_wr_en, rf_wa, alu_op, MARin, memEN, RW, MDRreadEN,
                  MDRout, MDRin, PCload, done, busy, halted, err};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] op);
        return (op == 4'h5 || op == 4'h6);
    endfunction

    // Cycle of the done pulse relative to the ir_valid cycle; 0 if the instruction never retires.
    function automatic int done_cyc(input logic [15:0] w, input int n);
        logic [3:0] op;
        op = w[15:12];
        if (op == 4'h0) return 3;
        if (op >= 4'h1 && op <= 4'h4) return 5;
        if (op == 4'h7) return 4;
        if (op == 4'h6 && n > 0) return 5 + n;
        if (op == 4'h5 && n > 0) return 6 + n;
        return 0;
    endfunction

    // First cycle the sticky halted/err flag is visible for non-retiring instructions.
    function automatic int term_cyc(input logic [15:0] w);
        return is_mem(w[15:12]) ? 4 + TO : 3;
    endfunction

    // Expected outputs k cycles after ir_valid; n = MEM_WAIT cycles (0: MFC never comes).
    function automatic logic [21:0] model(input logic [15:0] w, input int n, input int k);
        logic [3:0] op;
        logic [2:0] rd, ra, rb, e_ra, e_rb, e_wa;
        logic [1:0] e_alu;
        logic e_we, e_mar, e_men, e_rw, e_mrd, e_mout, e_min, e_pc, e_done, e_busy, e_halt, e_err;
        int d, t0, nw;
        op = w[15:12]; rd = w[11:9]; ra = w[8:6]; rb = w[5:3];
        {e_ra, e_rb, e_wa, e_alu} = '0;
        {e_we, e_mar, e_men, e_rw, e_mrd, e_mout, e_min, e_pc, e_done, e_busy, e_halt, e_err} = '0;
        d  = done_cyc(w, n);
        t0 = term_cyc(w);
        e_busy = (k >= 2) && ((d > 0) ? (k <= d) : (k < t0));
        e_done = (d > 0) && (k == d);
        if (d == 0 && k >= t0) begin
            if (op == 4'hF) e_halt = 1'b1;
            else            e_err  = 1'b1;
        end
        if (op >= 4'h1 && op <= 4'h4) begin
            if (k == 3) begin e_ra = ra; e_rb = rb; e_alu = 2'(op - 4'd1); end
            if (k == 4) begin e_we = 1'b1; e_wa = rd; end
        end
        if (op == 4'h7 && k == 3) e_pc = 1'b1;
        if (is_mem(op)) begin
            nw = (n > 0) ? n : TO;
            if (k == 3) e_mar = 1'b1;
            if (op == 4'h6 && k == 3) begin e_min = 1'b1; e_rb = rb; end
            if (k >= 4 && k <= 3 + nw) begin e_men = 1'b1; e_rw = (op == 4'h5); end
            if (op == 4'h5 && n > 0 && k == 4 + n) begin e_men = 1'b1; e_rw = 1'b1; e_mrd = 1'b1; end
            if (op == 4'h5 && n > 0 && k == 5 + n) begin e_mout = 1'b1; e_we = 1'b1; e_wa = rd; end
        end
        return {e_ra, e_rb, e_we, e_wa, e_alu, e_mar, e_men, e_rw, e_mrd, e_mout, e_min, e_pc,
                e_done, e_busy, e_halt, e_err};
    endfunction

    // MFC is forced inside the MEM_WAIT window and random everywhere else.
    function automatic logic mfc_drv(input logic [15:0] w, input int n, input int k);
        int nw;
        if (!is_mem(w[15:12])) return 1'($urandom);
        nw = (n > 0) ? n : TO;
        if (k >= 3 && k <= 2 + nw) return (n > 0) && (k == 2 + n);
        return 1'($urandom);
    endfunction

    task automatic do_reset();
        rst = 1'b0; ir_valid = 1'b1; ir = 16'($urandom); MFC = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d", i), 32'(got), 32'd0);
        end
        rst = 1'b1; ir_valid = 1'b0; MFC = 1'b0;
        @(posedge clk); #1;
        chk("post_rst", 32'(got), 32'd0);
    endtask

    // Issue w in the current cycle and check every following cycle; abort>0 pulls reset then.
    task automatic run(input logic [15:0] w, input int n, input int abort);
        int d, last;
        d    = done_cyc(w, n);
        last = (d > 0) ? d + 1 : term_cyc(w) + 3;
        ir_valid = 1'b1; ir = w; MFC = mfc_drv(w, n, 0);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            chk($sformatf("op%h_%h_n%0d_k%0d", w[15:12], w, n, k), 32'(got), 32'(model(w, n, k)));
            if (abort > 0 && k == abort) begin
                rst = 1'b0; ir_valid = 1'b0; MFC = 1'b0;
                @(posedge clk); #1;
                chk("abort", 32'(got), 32'd0);
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_idle", 32'(got), 32'd0);
                return;
            end
            if (k < last) begin
                ir_valid = (d == 0 || k <= d - 1) ? 1'($urandom) : 1'b0;
                ir       = 16'($urandom);
                MFC      = mfc_drv(w, n, k);
            end
        end
        ir_valid = 1'b0;
        if (d == 0) do_reset();
    endtask

    initial begin
        logic [3:0]  ops [10];
        logic [3:0]  op;
        logic [15:0] w;
        int          n;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h5, 4'h6};
        rst = 1'b0; ir_valid = 1'b0; ir = '0; MFC = 1'b0;
        do_reset();
        run(16'h1298, 0, 0);
        run(16'h5A05, 3, 0);
        run(16'h7123, 0, 0);
        run(16'h6A28, 1, 0);
        run(16'h6A28, TO, 0);
        run(16'h5A05, TO, 0);
        run(16'h6A28, 0, 0);
        run(16'h5A05, 0, 0);
        run(16'hF000, 0, 0);
        run(16'h9000, 0, 0);
        run(16'h5A05, 0, 5);
        run(16'h0000, 0, 0);
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 19) == 0) op = 4'($urandom_range(8, 15));
            else                            op = ops[$urandom_range(0, 9)];
            w = {op, 12'($urandom)};
            n = 0;
            if (is_mem(op)) n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
            run(w, n, ($urandom_range(0, 29) == 0) ? $urandom_range(2, 4) : 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
